// File: rtl/aes_key_expand_seq.sv
// ---------------------------------------------------------------------------
// aes_key_expand_seq
// Iterative AES-128/192/256 key schedule. One 32-bit schedule word is produced
// per clock through a single 4-byte SubWord bank. The whole schedule is kept
// in an internal register file, and round keys are read back through a
// combinational random-access port. Each new word is also streamed out.
//
// Optional build macro: AES_KEYEXP_REVERSE_RD_EN adds rd_rev_i. When it is
// set, rk_o serves round Nr - rk_idx_i, which is the decryption order.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   start_i       expansion request (sampled only in IDLE)
//   mode_i        00 AES-128, 01 AES-192, 10 AES-256, 11 reserved
//   key_i         cipher key, MSB-aligned
//   rd_rev_i      (macro only) reverse round-key order on the read port
//   busy_o        expansion in progress
//   done_o        one-cycle pulse when the last word is written
//   err_o         one-cycle pulse on a rejected start
//   key_valid_o   storage holds a complete schedule
//   w_valid_o     w_o / w_idx_o carry a freshly generated word
//   w_idx_o       schedule index of w_o
//   w_o           schedule word
//   rk_idx_i      round-key index 0..Nr
//   rk_o          {w[4r], w[4r+1], w[4r+2], w[4r+3]}, zero when r > Nr
// ---------------------------------------------------------------------------
module aes_key_expand_seq #(
    parameter int MAX_NK        = 8,
    parameter bit RST_CLR_STORE = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [1:0]   mode_i,
    input  logic [255:0] key_i,
`ifdef AES_KEYEXP_REVERSE_RD_EN
    input  logic         rd_rev_i,
`endif
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o,
    output logic         key_valid_o,
    output logic         w_valid_o,
    output logic [5:0]   w_idx_o,
    output logic [31:0]  w_o,
    input  logic [3:0]   rk_idx_i,
    output logic [127:0] rk_o
);

    localparam int DEPTH = 4 * (MAX_NK + 7);

    typedef enum logic {IDLE = 1'b0, EXPAND = 1'b1} state_t;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        // NOTE: blocking assignments are correct here; this is combinational
        // evaluation inside a function, not clocked state.
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // AES S-box: multiplicative inverse (a^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] store [DEPTH];
    logic [3:0]  nk_q, nr_q, nk_new;
    logic [5:0]  total_q, cnt_q;
    logic [2:0]  mod_q;
    logic [7:0]  rcon_q;
    logic        mode_ok, load, step, reject, last;
    logic [31:0] temp_raw, sub_in, sub_out, temp, new_w;
    logic [5:0]  prev_idx, back_idx;

    // Mode decode for the start request.
    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // path leaves it unassigned, which would infer a latch.
        nk_new = 4'd0;
        case (mode_i)
            2'b00:   nk_new = 4'd4;
            2'b01:   nk_new = 4'd6;
            2'b10:   nk_new = 4'd8;
            default: nk_new = 4'd0;
        endcase
        mode_ok = (mode_i != 2'b11) && (int'(nk_new) <= MAX_NK);
    end

    // FSM next state and per-cycle strobes.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        reject  = 1'b0;
        last    = (cnt_q == total_q - 6'd1);
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (mode_ok) begin
                        load    = 1'b1;
                        state_d = EXPAND;
                    end else begin
                        reject  = 1'b1;
                    end
                end
            end
            EXPAND: begin
                step = 1'b1;
                if (last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Next schedule word. mod_q tracks i mod Nk, so no divider is needed.
    always_comb begin
        prev_idx = cnt_q - 6'd1;
        back_idx = cnt_q - {2'b00, nk_q};
        temp_raw = store[prev_idx];
        sub_in   = (mod_q == 3'd0) ? {temp_raw[23:0], temp_raw[31:24]} : temp_raw;
        sub_out  = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
                    sbox(sub_in[15:8]),  sbox(sub_in[7:0])};
        if (mod_q == 3'd0)
            temp = sub_out ^ {rcon_q, 24'h000000};
        else if (nk_q == 4'd8 && mod_q == 3'd4)
            temp = sub_out;
        else
            temp = temp_raw;
        new_w = store[back_idx] ^ temp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            key_valid_o <= 1'b0;
            w_valid_o   <= 1'b0;
            w_idx_o     <= 6'd0;
            w_o         <= 32'h0;
            cnt_q       <= 6'd0;
            mod_q       <= 3'd0;
            rcon_q      <= 8'h01;
            nk_q        <= 4'd4;
            nr_q        <= 4'd10;
            total_q     <= 6'd44;
        end else begin
            state_q   <= state_d;
            busy_o    <= (state_d == EXPAND);
            done_o    <= step && last;
            err_o     <= reject;
            w_valid_o <= step;
            if (load) begin
                nk_q        <= nk_new;
                nr_q        <= nk_new + 4'd6;
                total_q     <= {nk_new, 2'b00} + 6'd28;
                cnt_q       <= {2'b00, nk_new};
                mod_q       <= 3'd0;
                rcon_q      <= 8'h01;
                key_valid_o <= 1'b0;
            end
            if (step) begin
                w_o     <= new_w;
                w_idx_o <= cnt_q;
                cnt_q   <= cnt_q + 6'd1;
                mod_q   <= ({1'b0, mod_q} == nk_q - 4'd1) ? 3'd0 : mod_q + 3'd1;
                if (mod_q == 3'd0)
                    rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                if (last) key_valid_o <= 1'b1;
            end
        end
    end

    // Schedule storage. Reset clearing is a build-time choice.
    generate
        if (RST_CLR_STORE) begin : g_store_rst
            // NOTE: resetting a storage array costs a reset path per bit;
            // the non-reset branch below exists to drop that cost.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int j = 0; j < DEPTH; j++) store[j] <= 32'h0;
                end else if (load) begin
                    for (int j = 0; j < 8; j++)
                        if (j < int'(nk_new)) store[j] <= key_i[255 - 32*j -: 32];
                end else if (step) begin
                    store[cnt_q] <= new_w;
                end
            end
        end else begin : g_store_norst
            always_ff @(posedge clk) begin
                if (load) begin
                    for (int j = 0; j < 8; j++)
                        if (j < int'(nk_new)) store[j] <= key_i[255 - 32*j -: 32];
                end else if (step) begin
                    store[cnt_q] <= new_w;
                end
            end
        end
    endgenerate

    // Round-key read port; indices past Nr of the latched mode read as zero.
    logic [3:0] rnd;
    logic [5:0] base;
    always_comb begin
        rk_o = 128'h0;
        rnd  = rk_idx_i;
`ifdef AES_KEYEXP_REVERSE_RD_EN
        if (rd_rev_i) rnd = nr_q - rk_idx_i;
`endif
        base = {rnd, 2'b00};
        if (rk_idx_i <= nr_q)
            rk_o = {store[base], store[base + 6'd1], store[base + 6'd2], store[base + 6'd3]};
    end

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// ---------------------------------------------------------------------------
// tb_aes_key_expand_seq
// Self-checking bench for aes_key_expand_seq: FIPS-197 known-answer vectors
// from a table, random keys against a table-driven reference schedule, and
// hand-written sequences for error, busy, back-to-back and reset corners.
// ---------------------------------------------------------------------------
module tb_aes_key_expand_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_i = 1'b0;
    logic [1:0]   mode_i = 2'b00;
    logic [255:0] key_i = '0;
    logic         rd_rev = 1'b0;
    logic         busy_o, done_o, err_o, key_valid_o, w_valid_o;
    logic [5:0]   w_idx_o;
    logic [31:0]  w_o;
    logic [3:0]   rk_idx_i = 4'd0;
    logic [127:0] rk_o;

    // Second instance limited to AES-128 without storage reset.
    logic         start4 = 1'b0;
    logic [1:0]   mode4 = 2'b00;
    logic         busy4, done4, err4, kv4, wv4;
    logic [5:0]   widx4;
    logic [31:0]  w4;
    logic [127:0] rk4;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    aes_key_expand_seq #(.MAX_NK(8), .RST_CLR_STORE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i), .key_i(key_i),
`ifdef AES_KEYEXP_REVERSE_RD_EN
        .rd_rev_i(rd_rev),
`endif
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .key_valid_o(key_valid_o),
        .w_valid_o(w_valid_o), .w_idx_o(w_idx_o), .w_o(w_o),
        .rk_idx_i(rk_idx_i), .rk_o(rk_o)
    );

    aes_key_expand_seq #(.MAX_NK(4), .RST_CLR_STORE(1'b0)) dut4 (
        .clk(clk), .rst_n(rst_n), .start_i(start4), .mode_i(mode4), .key_i(key_i),
`ifdef AES_KEYEXP_REVERSE_RD_EN
        .rd_rev_i(1'b0),
`endif
        .busy_o(busy4), .done_o(done4), .err_o(err4), .key_valid_o(kv4),
        .w_valid_o(wv4), .w_idx_o(widx4), .w_o(w4),
        .rk_idx_i(rk_idx_i), .rk_o(rk4)
    );

    // ---------------- reference model ----------------
    logic [7:0] sbox_tab [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };
    logic [7:0] rcon_tab [10] = '{8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36};

    logic [31:0] m_w [64];
    logic [31:0] cap_w [64];
    int m_nk, m_nr, m_t;

    function automatic logic [31:0] tb_sub(input logic [31:0] x);
        return {sbox_tab[x[31:24]], sbox_tab[x[23:16]], sbox_tab[x[15:8]], sbox_tab[x[7:0]]};
    endfunction

    task automatic build_model(input logic [1:0] mode, input logic [255:0] key);
        logic [31:0] t;
        m_nk = 4 + 2 * int'(mode);
        m_nr = m_nk + 6;
        m_t  = 4 * (m_nr + 1);
        for (int i = 0; i < 64; i++) m_w[i] = 32'h0;
        for (int i = 0; i < m_nk; i++) m_w[i] = key[255 - 32*i -: 32];
        for (int i = m_nk; i < m_t; i++) begin
            t = m_w[i-1];
            if (i % m_nk == 0)
                t = tb_sub({t[23:0], t[31:24]}) ^ {rcon_tab[i/m_nk - 1], 24'h0};
            else if (m_nk == 8 && i % 8 == 4)
                t = tb_sub(t);
            m_w[i] = m_w[i-m_nk] ^ t;
        end
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts an expansion at the current negedge (DUT must be IDLE), follows
    // the word stream against the model and returns at the negedge where
    // done_o is observed. lat is in edges after the start sampling edge.
    task automatic expand(input logic [1:0] mode, input logic [255:0] key, input bit hold_mid,
                          output int lat, output int dones);
        int nexp;
        int errs;
        build_model(mode, key);
        mode_i  = mode;
        key_i   = key;
        start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        mode_i  = 2'($urandom);
        key_i   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        check("busy_after_start", busy_o, 1'b1);
        check("kv_cleared_on_start", key_valid_o, 1'b0);
        nexp = m_nk; lat = -1; dones = 0; errs = 0;
        for (int k = 1; k <= 100 && lat < 0; k++) begin
            if (hold_mid) start_i = (k >= 5 && k < 15);
            @(posedge clk);
            @(negedge clk);
            if (err_o) errs++;
            if (w_valid_o) begin
                check("w_idx", w_idx_o, nexp[5:0]);
                if (nexp < 64) begin
                    check("w_word", w_o, m_w[nexp]);
                    cap_w[nexp] = w_o;
                end
                nexp++;
            end
            if (done_o) begin
                dones++;
                lat = k;
            end
        end
        start_i = 1'b0;
        check("latency", lat, m_t - m_nk);
        check("word_count", nexp, m_t);
        check("no_err_in_run", errs, 0);
        check("idle_at_done", busy_o, 1'b0);
        check("kv_at_done", key_valid_o, 1'b1);
    endtask

    typedef struct {
        logic [1:0]   mode;
        logic [255:0] key;
        int           ia;
        logic [31:0]  wa;
        int           ib;
        logic [31:0]  wb;
        logic [3:0]   rk;
        logic [127:0] rk_exp;
    } vec_t;

    vec_t vecs [3];

    initial begin
        int lat, dones, guard;
        logic [255:0] rkey;
        logic [1:0]   rmode;

        vecs[0] = '{2'b00, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                    4, 32'ha0fafe17, 43, 32'hb6630ca6, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[1] = '{2'b01, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0},
                    6, 32'hfe0c91f7, 51, 32'h01002202, 4'd13, 128'h0};
        vecs[2] = '{2'b10, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                    8, 32'h9ba35411, 59, 32'h706c631e, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_kv", key_valid_o, 1'b0);
        check("rst_wvalid", w_valid_o, 1'b0);
        check("rst_widx", w_idx_o, 6'd0);
        check("rst_w", w_o, 32'h0);
        check("rst_rk", rk_o, 128'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Known-answer table
        for (int v = 0; v < 3; v++) begin
            expand(vecs[v].mode, vecs[v].key, 1'b0, lat, dones);
            check("kat_wa", cap_w[vecs[v].ia], vecs[v].wa);
            check("kat_wb", cap_w[vecs[v].ib], vecs[v].wb);
            check("kat_dones", dones, 1);
            rk_idx_i = vecs[v].rk;
            #1 check("kat_rk", rk_o, vecs[v].rk_exp);
        end

        // Reserved mode rejected; schedule and key_valid_o untouched
        @(negedge clk);
        mode_i = 2'b11; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("err_pulse", err_o, 1'b1);
        check("err_busy", busy_o, 1'b0);
        check("err_kv_kept", key_valid_o, 1'b1);
        rk_idx_i = 4'd14;
        #1 check("err_store_kept", rk_o, {m_w[56], m_w[57], m_w[58], m_w[59]});
        @(negedge clk);
        check("err_one_cycle", err_o, 1'b0);

        // MAX_NK = 4 instance rejects AES-192/256, accepts AES-128
        mode4 = 2'b10; start4 = 1'b1;
        @(negedge clk);
        check("nk4_err_256", err4, 1'b1);
        check("nk4_busy_256", busy4, 1'b0);
        mode4 = 2'b01;
        @(negedge clk);
        check("nk4_err_192", err4, 1'b1);
        mode4 = 2'b00;
        @(negedge clk);
        start4 = 1'b0;
        check("nk4_err_128", err4, 1'b0);
        check("nk4_busy_128", busy4, 1'b1);

        // Start held during busy is ignored; then start on the done cycle
        expand(2'b00, {$urandom, $urandom, $urandom, $urandom, 128'h0}, 1'b1, lat, dones);
        check("hold_single_done", dones, 1);
        rmode = 2'($urandom_range(2));
        rkey  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        expand(rmode, rkey, 1'b0, lat, dones);

        // Random keys and modes, every round key read back
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            rmode = 2'($urandom_range(2));
            rkey  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            expand(rmode, rkey, 1'b0, lat, dones);
            for (int r = 0; r <= 15; r++) begin
                rk_idx_i = 4'(r);
                if (r <= m_nr)
                    #1 check("rand_rk", rk_o, {m_w[4*r], m_w[4*r+1], m_w[4*r+2], m_w[4*r+3]});
                else
                    #1 check("rand_rk_zero", rk_o, 128'h0);
            end
        end

        // Asynchronous reset at word 20 of an AES-128 run
        @(negedge clk);
        mode_i = 2'b00; key_i = vecs[0].key; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        guard = 0;
        while (!(w_valid_o && w_idx_o == 6'd20) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("reach_word20", guard < 100, 1'b1);
        #2 rst_n = 1'b0;
        rk_idx_i = 4'd0;
        #1;
        check("arst_busy", busy_o, 1'b0);
        check("arst_kv", key_valid_o, 1'b0);
        check("arst_wvalid", w_valid_o, 1'b0);
        check("arst_widx", w_idx_o, 6'd0);
        check("arst_w", w_o, 32'h0);
        check("arst_done_err", {done_o, err_o}, 2'b00);
        check("arst_rk", rk_o, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("kv_after_rst", key_valid_o, 1'b0);

        // Fresh AES-128 run after reset
        expand(vecs[0].mode, vecs[0].key, 1'b0, lat, dones);
        rk_idx_i = 4'd10;
        #1 check("rk10_after_rst", rk_o, vecs[0].rk_exp);
`ifdef AES_KEYEXP_REVERSE_RD_EN
        rd_rev = 1'b1;
        rk_idx_i = 4'd0;
        #1 check("rev_rk0", rk_o, vecs[0].rk_exp);
        rk_idx_i = 4'd11;
        #1 check("rev_rk_zero", rk_o, 128'h0);
        rd_rev = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
